// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The fetch queue, its FIFO and the bench all use these definitions.
package instr_fetch_queue_pkg;

  localparam int          WORD_W       = 32;
  localparam int          INSTR_BYTES  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } ifq_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } ifq_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~(WORD_W'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular FIFO of {pc, instr} entries for the fetch queue.
// When empty, dout holds the most recently popped entry.
module ifq_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  ifq_entry_t               din,
  output ifq_entry_t               dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t        mem_q [DEPTH];
  ifq_entry_t        last_q, last_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & (cnt_q != '0);
  assign do_push = push & ((cnt_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop) begin
        rd_d   = rd_q + AW'(1);
        last_d = mem_q[rd_q];
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  // Storage needs no reset: an empty FIFO presents last_q, never the array.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

  assign dout  = (cnt_q == '0) ? last_q : mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: private fetch PC, word requests to synchronous imem, FIFO to decode.
//   state | meaning
//   BOOT  | first cycle after reset release, no requests
//   RUN   | normal fetch, requests when enabled and FIFO has room
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetch_en,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic [31:0]             imem_rdata,
  output logic                    out_valid,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_pc,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic          req;
  logic          push;
  logic          pop;
  logic [CW:0]   pending;
  logic [CW-1:0] count;
  ifq_entry_t    fifo_din;
  ifq_entry_t    fifo_dout;

  // Occupancy plus the outstanding request, one bit wider so DEPTH fits.
  assign pending = {1'b0, count} + {{CW{1'b0}}, inflight_q};

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    kill_d     = redirect_valid;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     req = fetch_en & ~redirect_valid & (pending < (CW+1)'(DEPTH));
      default: state_d = BOOT;
    endcase
    if (req) begin
      fpc_d      = fpc_q + 32'(INSTR_BYTES);
      req_pc_d   = fpc_q;
      inflight_d = 1'b1;
    end
    if (redirect_valid) fpc_d = word_align(redirect_pc);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      fpc_q      <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  // A response from before a redirect must never reach the FIFO.
  assign push     = inflight_q & ~kill_q;
  assign pop      = out_valid & out_ready;
  assign fifo_din = '{pc: req_pc_q, instr: imem_rdata};

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count)
  );

  assign imem_req  = req;
  assign imem_addr = fpc_q;
  assign out_valid = (count != '0);
  assign out_instr = fifo_dout.instr;
  assign out_pc    = fifo_dout.pc;
  assign occupancy = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a one-cycle-latency imem model.
// Instruction memory content: word at byte address a is (a/4)*16+1.
module tb_instr_fetch_queue;

  logic        clock;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  int base;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .occupancy      (occupancy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (imem_req) begin
      imem_rdata <= (imem_addr << 2) + 32'd1;
      req_cnt    <= req_cnt + 1;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(imem_req),  32'h0);
    chk({tag, "_addr"},  imem_addr,      32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_instr"}, out_instr,      32'h0);
    chk({tag, "_pc"},    out_pc,         32'h0);
    chk({tag, "_occ"},   32'(occupancy), 32'h0);
  endtask

  initial begin
    reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    #2;
    chk_reset_vals("rst");
    cyc(); cyc();

    // streaming after reset release
    cyc(); reset = 1'b1; fetch_en = 1'b1; out_ready = 1'b1; #1;
    chk("t1_boot_req", 32'(imem_req), 32'h0);
    cyc(); #1;
    chk("t1_req0", 32'(imem_req), 32'h1);
    chk("t1_addr0", imem_addr, 32'h0);
    cyc(); #1;
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_valid_early", 32'(out_valid), 32'h0);
    cyc(); #1;
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_instr0", out_instr, 32'h1);
    chk("t1_addr8", imem_addr, 32'h8);
    cyc(); #1;
    chk("t1_pc4", out_pc, 32'h4);
    chk("t1_instr4", out_instr, 32'h11);
    chk("t1_occ", 32'(occupancy), 32'h1);

    // fill with decode stalled
    reset = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    cyc(); reset = 1'b1; base = req_cnt; #1;
    chk("t2_boot_req", 32'(imem_req), 32'h0);
    cyc(); #1;
    chk("t2_addr0", imem_addr, 32'h0);
    chk("t2_req0", 32'(imem_req), 32'h1);
    cyc(); cyc(); cyc(); #1;
    chk("t2_addr12", imem_addr, 32'hC);
    chk("t2_req12", 32'(imem_req), 32'h1);
    cyc(); #1;
    chk("t2_stop", 32'(imem_req), 32'h0);
    cyc(); #1;
    chk("t2_occ_full", 32'(occupancy), 32'h4);
    chk("t2_full_req", 32'(imem_req), 32'h0);
    chk("t2_head", out_pc, 32'h0);
    chk("t2_req_count", 32'(req_cnt - base), 32'h4);
    cyc(); out_ready = 1'b1; #1;
    chk("t2_pop_cycle_req", 32'(imem_req), 32'h0);
    cyc(); out_ready = 1'b0; #1;
    chk("t2_refill_req", 32'(imem_req), 32'h1);
    chk("t2_refill_addr", imem_addr, 32'h10);
    chk("t2_occ3", 32'(occupancy), 32'h3);
    chk("t2_head4", out_pc, 32'h4);
    cyc(); #1;
    chk("t2_refill_stop", 32'(imem_req), 32'h0);

    // redirect with occupancy 3 and a response arriving
    cyc(); out_ready = 1'b1; #1;
    cyc(); out_ready = 1'b0; #1;
    chk("t3_pre_addr", imem_addr, 32'h14);
    chk("t3_pre_req", 32'(imem_req), 32'h1);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("t3_T_req", 32'(imem_req), 32'h0);
    chk("t3_T_occ", 32'(occupancy), 32'h3);
    cyc(); redirect_valid = 1'b0; #1;
    chk("t3_flush_occ", 32'(occupancy), 32'h0);
    chk("t3_flush_valid", 32'(out_valid), 32'h0);
    chk("t3_new_req", 32'(imem_req), 32'h1);
    chk("t3_new_addr", imem_addr, 32'h100);
    cyc(); #1;
    chk("t3_T2_valid", 32'(out_valid), 32'h0);
    chk("t3_T2_addr", imem_addr, 32'h104);
    cyc(); #1;
    chk("t3_T3_valid", 32'(out_valid), 32'h1);
    chk("t3_T3_pc", out_pc, 32'h100);
    chk("t3_T3_instr", out_instr, 32'h401);
    chk("t3_T3_occ", 32'(occupancy), 32'h1);

    // simultaneous push and pop at occupancy 2, then redirect with a pop
    cyc(); out_ready = 1'b1; #1;
    chk("t5_occ2", 32'(occupancy), 32'h2);
    chk("t5_head", out_pc, 32'h100);
    chk("t5_addr", imem_addr, 32'h10C);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
    chk("t5_occ_kept", 32'(occupancy), 32'h2);
    chk("t5_order_pc", out_pc, 32'h104);
    chk("t5_order_instr", out_instr, 32'h411);
    chk("t5_redir_req", 32'(imem_req), 32'h0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("t5_flush_occ", 32'(occupancy), 32'h0);
    chk("t5_flush_valid", 32'(out_valid), 32'h0);
    chk("t4_align_addr", imem_addr, 32'h200);
    chk("t4_align_req", 32'(imem_req), 32'h1);
    cyc(); #1;
    chk("t4_align_addr2", imem_addr, 32'h204);
    cyc(); #1;
    chk("t4_align_valid", 32'(out_valid), 32'h1);
    chk("t4_align_pc", out_pc, 32'h200);
    chk("t4_align_instr", out_instr, 32'h801);

    // pc wrap
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("t4_wrap_T_req", 32'(imem_req), 32'h0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("t4_wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("t4_wrap_req", 32'(imem_req), 32'h1);
    cyc(); #1;
    chk("t4_wrap_addr_zero", imem_addr, 32'h0);
    cyc(); #1;
    chk("t4_wrap_pc_top", out_pc, 32'hFFFF_FFFC);
    chk("t4_wrap_instr_top", out_instr, 32'hFFFF_FFF1);
    cyc(); #1;
    chk("t4_wrap_pc_zero", out_pc, 32'h0);
    chk("t4_wrap_instr_zero", out_instr, 32'h1);

    // back-to-back redirects while fetch is disabled
    cyc(); fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
    chk("bb_T_req", 32'(imem_req), 32'h0);
    cyc(); redirect_pc = 32'h400; #1;
    chk("bb_occ", 32'(occupancy), 32'h0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("bb_last_wins", imem_addr, 32'h400);
    chk("bb_no_req", 32'(imem_req), 32'h0);
    chk("bb_occ2", 32'(occupancy), 32'h0);
    cyc(); fetch_en = 1'b1; out_ready = 1'b0; #1;
    chk("bb_resume_req", 32'(imem_req), 32'h1);
    chk("bb_resume_addr", imem_addr, 32'h400);

    // reset mid-stream
    cyc(); cyc(); cyc(); cyc(); #1;
    chk("t6_pre_occ", 32'(occupancy), 32'h3);
    chk("t6_pre_req", 32'(imem_req), 32'h0);
    reset = 1'b0; #1;
    chk_reset_vals("t6_async");
    cyc(); cyc();
    reset = 1'b1; #1;
    chk("t6_boot_req", 32'(imem_req), 32'h0);
    chk("t6_boot_addr", imem_addr, 32'h0);
    cyc(); #1;
    chk("t6_first_req", 32'(imem_req), 32'h1);
    chk("t6_first_addr", imem_addr, 32'h0);
    cyc(); #1;
    chk("t6_valid_early", 32'(out_valid), 32'h0);
    cyc(); #1;
    chk("t6_valid", 32'(out_valid), 32'h1);
    chk("t6_pc", out_pc, 32'h0);
    chk("t6_instr", out_instr, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
